// File: rtl/spi_boot_loader.sv
// SPI-to-CW-bus boot loader: each LSB-first serial frame becomes one 16-bit bus
// transaction, acknowledged on miso with a single 0 bit (plus read data for reads).
module spi_boot_loader #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
) (
  input  logic              cw_clk,
  input  logic              cw_rst,
  input  logic              en,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [DATA_W-1:0] wb_o_dat,
  input  logic [DATA_W-1:0] wb_i_dat,
  input  logic              wb_ack,
  input  logic              wb_err,
  output logic              busy,
  output logic              err_sticky,
  output logic [2:0]        o_dbg_state
);

  // Bus handshake: cyc/stb stay high from request until (and including) the
  // cycle where wb_ack or wb_err is seen, and are low on the following cycle.

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WE    = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_BUS   = 3'd4;
  localparam logic [2:0] S_ACK   = 3'd5;
  localparam logic [2:0] S_RDOUT = 3'd6;

  logic [1:0]        r_sclk_s;
  logic [1:0]        r_mosi_s;
  logic              r_sclk_d;
  logic              r_rise;
  logic              r_fall;
  logic              r_mosi_q;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;
  logic [DATA_W-1:0] r_rdat;
  logic              r_we;
  logic              r_cyc;
  logic              r_miso;
  logic              r_phase;
  logic              r_abort;
  logic              r_err;
  logic              w_done;

  // Synchronisers reset to the idle-high level so reset release never looks like a start bit.
  always_ff @(posedge cw_clk or posedge cw_rst) begin
    if (cw_rst) begin
      r_sclk_s <= 2'b11;
      r_mosi_s <= 2'b11;
      r_sclk_d <= 1'b1;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_mosi_q <= 1'b1;
    end else begin
      r_sclk_s <= {r_sclk_s[0], spi_clk};
      r_mosi_s <= {r_mosi_s[0], spi_mosi};
      r_sclk_d <= r_sclk_s[1];
      r_rise   <= r_sclk_s[1] & ~r_sclk_d;
      r_fall   <= ~r_sclk_s[1] & r_sclk_d;
      r_mosi_q <= r_mosi_s[1];
    end
  end

  assign w_done = r_cyc & (wb_ack | wb_err);

  always_ff @(posedge cw_clk or posedge cw_rst) begin
    if (cw_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_rdat  <= '0;
      r_we    <= 1'b0;
      r_cyc   <= 1'b0;
      r_miso  <= 1'b1;
      r_phase <= 1'b0;
      r_abort <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_miso <= 1'b1;
          if (en && r_rise && !r_mosi_q) begin
            r_state <= S_ADDR;
            r_cnt   <= '0;
          end
        end
        S_ADDR: begin
          if (!en) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_rise) begin
            r_adr <= {r_mosi_q, r_adr[ADDR_W-1:1]};
            if (r_cnt == CNT_W'(ADDR_W - 1)) begin
              r_cnt   <= '0;
              r_state <= S_WE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_WE: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else if (r_rise) begin
            r_we <= r_mosi_q;
            if (r_mosi_q) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_BUS;
              r_cyc   <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (!en) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_rise) begin
            r_dat <= {r_mosi_q, r_dat[DATA_W-1:1]};
            if (r_cnt == CNT_W'(DATA_W - 1)) begin
              r_cnt   <= '0;
              r_state <= S_BUS;
              r_cyc   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_BUS: begin
          // A disable during the bus cycle is remembered; the transfer still completes.
          if (!en) r_abort <= 1'b1;
          if (w_done) begin
            r_cyc   <= 1'b0;
            r_rdat  <= wb_err ? '0 : wb_i_dat;
            if (wb_err) r_err <= 1'b1;
            r_abort <= 1'b0;
            r_phase <= 1'b0;
            r_state <= (r_abort || !en) ? S_IDLE : S_ACK;
          end
        end
        S_ACK: begin
          if (!en) begin
            r_state <= S_IDLE;
            r_miso  <= 1'b1;
          end else if (r_fall) begin
            if (!r_phase) begin
              r_miso  <= 1'b0;
              r_phase <= 1'b1;
            end else if (r_we) begin
              r_miso  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_miso  <= r_rdat[0];
              r_rdat  <= {1'b0, r_rdat[DATA_W-1:1]};
              r_cnt   <= CNT_W'(1);
              r_state <= S_RDOUT;
            end
          end
        end
        S_RDOUT: begin
          if (!en) begin
            r_state <= S_IDLE;
            r_miso  <= 1'b1;
            r_cnt   <= '0;
          end else if (r_fall) begin
            if (r_cnt == CNT_W'(DATA_W)) begin
              r_miso  <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_miso <= r_rdat[0];
              r_rdat <= {1'b0, r_rdat[DATA_W-1:1]};
              r_cnt  <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_miso  <= 1'b1;
          r_cyc   <= 1'b0;
        end
      endcase
    end
  end

  assign spi_miso    = r_miso;
  assign wb_cyc      = r_cyc;
  assign wb_stb      = r_cyc;
  assign wb_we       = r_we;
  assign wb_adr      = r_adr;
  assign wb_o_dat    = r_dat;
  assign busy        = (r_state != S_IDLE);
  assign err_sticky  = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_boot_loader.sv
// Bench for spi_boot_loader: bit-level SPI master, Wishbone-style responder and
// a transaction-level expectation model.
module tb_spi_boot_loader;
  localparam int AW   = 24;
  localparam int DW   = 16;
  localparam int HALF = 6;
  localparam int W    = 41;

  logic          cw_clk   = 1'b0;
  logic          cw_rst   = 1'b1;
  logic          en       = 1'b0;
  logic          spi_clk  = 1'b1;
  logic          spi_mosi = 1'b1;
  logic          spi_miso;
  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_o_dat;
  logic [DW-1:0] wb_i_dat = '0;
  logic          wb_ack   = 1'b0;
  logic          wb_err   = 1'b0;
  logic          busy;
  logic          err_sticky;
  logic [2:0]    o_dbg_state;

  spi_boot_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .cw_clk(cw_clk), .cw_rst(cw_rst), .en(en),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_o_dat(wb_o_dat), .wb_i_dat(wb_i_dat), .wb_ack(wb_ack), .wb_err(wb_err),
    .busy(busy), .err_sticky(err_sticky), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 cw_clk = ~cw_clk;

  initial begin
    #3ms;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;

  // scoreboard: {we, adr, dat} per expected bus transaction, in order
  logic [W-1:0] exp_q[$];
  int           rsp_delay = 2;
  logic         rsp_err   = 1'b0;
  logic         rsp_hold  = 1'b0;
  logic [DW-1:0] rd_value = '0;
  int           rsp_cnt   = 0;
  int           txn_count = 0;
  logic         err_model = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bus responder, driven away from the active edge
  always @(negedge cw_clk) begin
    logic [W-1:0] e;
    if (wb_ack || wb_err) begin
      wb_ack = 1'b0;
      wb_err = 1'b0;
      chk("cyc_drop_after_ack", {63'd0, wb_cyc}, 64'd0);
    end else if (wb_cyc && !rsp_hold && !cw_rst) begin
      chk("stb_with_cyc", {63'd0, wb_stb}, 64'd1);
      rsp_cnt++;
      if (rsp_cnt >= rsp_delay) begin
        rsp_cnt = 0;
        txn_count++;
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_txn observed=%0h expected=none", {wb_we, wb_adr, wb_o_dat});
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (e[W-1]) chk("bus_write", 64'({wb_we, wb_adr, wb_o_dat}), 64'(e));
          else        chk("bus_read", 64'({wb_we, wb_adr}), 64'(e[W-1:DW]));
        end
        if (rsp_err) begin
          wb_err   = 1'b1;
          wb_i_dat = DW'($urandom);
        end else begin
          wb_ack   = 1'b1;
          wb_i_dat = rd_value;
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge cw_clk);
      #1;
    end
  endtask

  // master shifts mosi on fall, samples miso just before the rise
  task automatic spi_bit(input logic b, output logic m);
    spi_clk  = 1'b0;
    spi_mosi = b;
    tick(HALF);
    m       = spi_miso;
    spi_clk = 1'b1;
    tick(HALF);
  endtask

  task automatic send_frame(input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] dat,
                            input logic poll, output logic got_ack);
    logic m;
    logic any0;
    any0 = 1'b0;
    spi_bit(1'b0, m); any0 |= ~m;
    for (int i = 0; i < AW; i++) begin spi_bit(adr[i], m); any0 |= ~m; end
    spi_bit(we, m); any0 |= ~m;
    if (we) for (int i = 0; i < DW; i++) begin spi_bit(dat[i], m); any0 |= ~m; end
    chk("miso_high_during_frame", {63'd0, any0}, 64'd0);
    got_ack = 1'b0;
    if (poll) begin
      for (int i = 0; i < 100 && !got_ack; i++) begin
        spi_bit(1'b1, m);
        if (!m) got_ack = 1'b1;
      end
    end
  endtask

  task automatic do_frame(input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] dat,
                          input int delay, input logic err, input logic [DW-1:0] rdv);
    logic got;
    logic m;
    logic [DW-1:0] rd;
    rsp_delay = delay;
    rsp_err   = err;
    rd_value  = rdv;
    exp_q.push_back({we, adr, dat});
    send_frame(adr, we, dat, 1'b1, got);
    chk("ack_bit_seen", {63'd0, got}, 64'd1);
    if (!we) begin
      rd = '0;
      for (int i = 0; i < DW; i++) begin
        spi_bit(1'b1, m);
        rd[i] = m;
      end
      chk("read_data", 64'(rd), 64'(err ? 16'h0000 : rdv));
    end
    spi_bit(1'b1, m);
    chk("miso_high_after", {63'd0, m}, 64'd1);
    if (err) err_model = 1'b1;
    chk("err_sticky", {63'd0, err_sticky}, {63'd0, err_model});
    chk("busy_idle", {63'd0, busy}, 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic m;
    logic got;
    logic any0;
    int   base;

    // reset values
    tick(3);
    chk("rst_miso", {63'd0, spi_miso}, 64'd1);
    chk("rst_cyc", {63'd0, wb_cyc}, 64'd0);
    chk("rst_stb", {63'd0, wb_stb}, 64'd0);
    chk("rst_we", {63'd0, wb_we}, 64'd0);
    chk("rst_adr", 64'(wb_adr), 64'd0);
    chk("rst_dat", 64'(wb_o_dat), 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_err", {63'd0, err_sticky}, 64'd0);
    cw_rst = 1'b0;
    en     = 1'b1;
    tick(4);
    chk("idle_after_rst", 64'(o_dbg_state), 64'd0);

    // directed write and read
    do_frame(24'h800010, 1'b1, 16'h3888, 2, 1'b0, 16'h0000);
    do_frame(24'h000123, 1'b0, 16'h0000, 2, 1'b0, 16'hA5C3);

    // 64 back-to-back writes
    base = txn_count;
    for (int i = 0; i < 64; i++)
      do_frame(24'h800000 + 24'(i), 1'b1, 16'h1000 + 16'(i), $urandom_range(1, 3), 1'b0, 16'h0000);
    chk("burst_txn_count", 64'(txn_count - base), 64'd64);

    // bus error on write, then a normal write and an errored read
    do_frame(24'h000000, 1'b1, 16'hBEEF, 2, 1'b1, 16'h0000);
    do_frame(24'h000001, 1'b1, 16'h0001, 1, 1'b0, 16'h0000);
    do_frame(24'h000002, 1'b0, 16'h0000, 3, 1'b1, 16'hFFFF);

    // disable after 10 address bits
    base = txn_count;
    spi_bit(1'b0, m);
    for (int i = 0; i < 10; i++) spi_bit(1'(i % 3 == 0), m);
    en = 1'b0;
    tick(2);
    chk("en_drop_busy", {63'd0, busy}, 64'd0);
    chk("en_drop_state", 64'(o_dbg_state), 64'd0);
    chk("en_drop_miso", {63'd0, spi_miso}, 64'd1);
    any0 = 1'b0;
    for (int i = 0; i < 45; i++) begin
      spi_bit((i == 0) ? 1'b0 : 1'($urandom_range(0, 1)), m);
      any0 |= ~m;
    end
    chk("disabled_miso_high", {63'd0, any0}, 64'd0);
    chk("disabled_no_txn", 64'(txn_count - base), 64'd0);
    en = 1'b1;
    tick(2);
    do_frame(24'h5A5A5A, 1'b1, 16'hC0DE, 2, 1'b0, 16'h0000);

    // reset while the bus cycle is held open
    rsp_hold = 1'b1;
    exp_q.push_back({1'b1, 24'h000042, 16'h1234});
    send_frame(24'h000042, 1'b1, 16'h1234, 1'b0, got);
    for (int i = 0; i < 50 && !wb_cyc; i++) tick(1);
    chk("cyc_before_rst", {63'd0, wb_cyc}, 64'd1);
    tick(3);
    cw_rst = 1'b1;
    #1;
    chk("rst_mid_cyc", {63'd0, wb_cyc}, 64'd0);
    chk("rst_mid_stb", {63'd0, wb_stb}, 64'd0);
    chk("rst_mid_miso", {63'd0, spi_miso}, 64'd1);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_err", {63'd0, err_sticky}, 64'd0);
    tick(2);
    cw_rst    = 1'b0;
    rsp_hold  = 1'b0;
    rsp_cnt   = 0;
    err_model = 1'b0;
    exp_q.delete();
    tick(4);
    do_frame(24'h00ABCD, 1'b0, 16'h0000, 2, 1'b0, 16'h6E21);

    // randomized frames
    for (int i = 0; i < 16; i++)
      do_frame(AW'($urandom), 1'($urandom_range(0, 1)), DW'($urandom), $urandom_range(1, 4),
               1'($urandom_range(0, 5) == 0), DW'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
